// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd: drains an FWFT FIFO as sop/eop-framed bursts into a one-word output register.
// Optional build macro FIFO_BURST_RD_TIMEOUT_EN adds an idle timer that flushes partial bursts.
module fifo_burst_rd #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic [AW:0]   fifo_rd_space,
    output logic          fifo_rd_en,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sop,
    output logic          m_eop,
    output logic          busy
);
    localparam logic [AW:0] BL  = (AW+1)'(BURST_LEN);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    if (BURST_LEN < 1 || BURST_LEN > 2**AW || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_burst_rd: BURST_LEN must be 1..2**AW and TIMEOUT >= 1");
    end

    typedef enum logic {IDLE, BURST} state_t;
    state_t      state;
    logic [AW:0] cnt, len;
    logic        last, full_burst, expired;

    assign full_burst = fifo_rd_space >= BL;
    assign last       = cnt == len - ONE;
    assign fifo_rd_en = rst_n && state == BURST && !fifo_empty && cnt < len && (!m_valid || m_ready);
    assign busy       = state != IDLE || m_valid;

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    localparam int            TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TM = TW'(TIMEOUT);
    logic [TW-1:0] timer;
    logic          partial;

    assign partial = state == IDLE && fifo_rd_space != '0 && !full_burst;
    assign expired = partial && timer == TM;

    // Count idle cycles with a residual below a full burst, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst_n || !partial) timer <= '0;
        else if (!expired) timer <= timer + TW'(1);
    end
`else
    assign expired = 1'b0;
`endif

    // Burst FSM plus the output register; a pop always refills the register on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            len     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (full_burst || expired) begin
                    state <= BURST;
                    cnt   <= '0;
                    len   <= full_burst ? BL : fifo_rd_space;
                end
            end else if (fifo_rd_en) begin
                cnt <= cnt + ONE;
                if (last) state <= IDLE;
            end
            if (fifo_rd_en) begin
                m_data  <= fifo_dout;
                m_valid <= 1'b1;
                m_sop   <= cnt == '0;
                m_eop   <= last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_rd.sv
// tb_fifo_burst_rd: directed scoreboard bench for fifo_burst_rd with a behavioural FWFT FIFO.
module tb_fifo_burst_rd;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_ready = 1'b1;
    logic [DW-1:0] fifo_dout, m_data;
    logic          fifo_empty, fifo_rd_en, m_valid, m_sop, m_eop, busy;
    logic [AW:0]   fifo_rd_space;

    logic [DW-1:0] mem [0:255];
    int            wp = 0, rp = 0;
    bit            flush = 1'b0, stale = 1'b0, gap_en = 1'b0;
    logic [AW:0]   stale_val = '0;
    logic [DW+1:0] sb [$];
    int            n_chk = 0, n_fail = 0, cyc = 0, last_eop = 0;
    logic          p_ok = 1'b0, p_rd = 1'b0, p_hold = 1'b0;
    logic [DW-1:0] p_head = '0;
    logic [DW+1:0] p_out = '0;

    always #5 clk = ~clk;

    fifo_burst_rd #(.DW(DW), .AW(AW), .BURST_LEN(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_space(fifo_rd_space), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop), .busy(busy)
    );

    assign fifo_empty    = wp == rp;
    assign fifo_dout     = mem[rp];
    assign fifo_rd_space = stale ? stale_val : (AW+1)'(wp - rp);

    always @(posedge clk) begin
        if (flush) rp <= wp;
        else if (fifo_rd_en && wp != rp) rp <= rp + 1;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit s, input bit e);
        mem[wp] = d;
        wp++;
        sb.push_back({d, s, e});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            tick;
            k++;
        end
        chk(sb.size() == 0, "drain", sb.size(), 0);
        repeat (2) tick;
    endtask

    task automatic wait_data(input logic [DW-1:0] d);
        int k;
        k = 0;
        while (!(m_valid && m_data == d) && k < 50) begin
            tick;
            k++;
        end
        chk(k < 50, "wait_beat", k, d);
    endtask

    // Monitor: scoreboard pops on each handshake plus protocol checks on every cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (fifo_empty) chk(!fifo_rd_en, "rd_en_while_empty", fifo_rd_en, 0);
            if (p_ok && p_rd) chk(m_valid && m_data == p_head, "load_latency", {m_valid, m_data}, {1'b1, p_head});
            if (p_ok && p_hold) chk({m_valid, m_data, m_sop, m_eop} == {1'b1, p_out}, "hold_stable",
                                    {m_valid, m_data, m_sop, m_eop}, {1'b1, p_out});
            if (m_valid && !m_ready) chk(!fifo_rd_en, "rd_en_while_held", fifo_rd_en, 0);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk(1'b0, "unexpected_beat", {m_data, m_sop, m_eop}, 0);
                else begin
                    chk({m_data, m_sop, m_eop} == sb[0], "beat", {m_data, m_sop, m_eop}, sb[0]);
                    void'(sb.pop_front());
                end
                if (m_eop) last_eop <= cyc;
                if (gap_en && m_sop && m_data == 8'h64) chk(cyc - last_eop <= 2, "burst_gap", cyc - last_eop, 2);
            end
        end
        p_ok   <= rst_n;
        p_rd   <= fifo_rd_en;
        p_head <= fifo_dout;
        p_hold <= m_valid && !m_ready;
        p_out  <= {m_data, m_sop, m_eop};
    end

    initial begin
        repeat (3) tick;
        chk(!m_valid, "rst_m_valid", m_valid, 0);
        chk(!m_sop, "rst_m_sop", m_sop, 0);
        chk(!m_eop, "rst_m_eop", m_eop, 0);
        chk(m_data == 0, "rst_m_data", m_data, 0);
        chk(!busy, "rst_busy", busy, 0);
        chk(!fifo_rd_en, "rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        tick;
        // single 4-beat burst, sink always ready
        push(8'hA0, 1, 0); push(8'hA1, 0, 0); push(8'hA2, 0, 0); push(8'hA3, 0, 1);
        drain;
        // sink stalls 5 cycles on beat 2
        push(8'hB0, 1, 0); push(8'hB1, 0, 0); push(8'hB2, 0, 0); push(8'hB3, 0, 1);
        wait_data(8'hB2);
        m_ready = 1'b0;
        repeat (5) tick;
        chk(m_valid && m_data == 8'hB2, "held_b2", {m_valid, m_data}, {1'b1, 8'hB2});
        chk(!fifo_rd_en, "held_no_rd", fifo_rd_en, 0);
        m_ready = 1'b1;
        drain;
        // FIFO runs empty mid-burst while rd_space still reports 4
        stale = 1'b1;
        stale_val = 4;
        push(8'hC0, 1, 0); push(8'hC1, 0, 0);
        repeat (4) tick;
        chk(fifo_empty && !fifo_rd_en && busy, "empty_stall", {fifo_empty, fifo_rd_en, busy}, 3'b101);
        repeat (2) tick;
        push(8'hC2, 0, 0); push(8'hC3, 0, 1);
        stale = 1'b0;
        drain;
        // residual below BURST_LEN
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        push(8'hD0, 1, 0); push(8'hD1, 0, 1);
`else
        push(8'hD0, 1, 0); push(8'hD1, 0, 0);
`endif
        repeat (100) tick;
`ifndef FIFO_BURST_RD_TIMEOUT_EN
        chk(!m_valid && !busy && sb.size() == 2, "no_partial_burst", {m_valid, busy, sb.size()}, 2);
        push(8'hD2, 0, 0); push(8'hD3, 0, 1);
`else
        chk(sb.size() == 0, "timeout_burst", sb.size(), 0);
        push(8'hD2, 1, 0); push(8'hD3, 0, 1);
`endif
        drain;
        // reset while beat 1 is presented
        push(8'hE0, 1, 0); push(8'hE1, 0, 0); push(8'hE2, 0, 0); push(8'hE3, 0, 1);
        wait_data(8'hE1);
        rst_n = 1'b0;
        sb.delete();
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk(!m_valid, "midrst_m_valid", m_valid, 0);
        chk(!busy, "midrst_busy", busy, 0);
        chk(!fifo_rd_en && !m_eop, "midrst_rd_eop", {fifo_rd_en, m_eop}, 0);
        rst_n = 1'b1;
        tick;
        push(8'hF0, 1, 0); push(8'hF1, 0, 0); push(8'hF2, 0, 0); push(8'hF3, 0, 1);
        drain;
        // back-to-back bursts from 8 words
        gap_en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i), i % 4 == 0, i % 4 == 3);
        drain;
        gap_en = 1'b0;
        repeat (3) tick;
        chk(!busy, "final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
